// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullsub.sv
// Single-bit full subtractor cell: d = a - b - bin, borrow out on bout.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB-first, one bit per clock through a fullsub cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_d, bit_br;
  logic             last_bit;

  fullsub u_fullsub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_br)
  );

  always_comb begin
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Result bits accumulate in res_sr; diff/bout only change on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {bit_d, res_sr[WIDTH-1:1]};
          br     <= bit_br;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff <= {bit_d, res_sr[WIDTH-1:1]};
            bout <= bit_br;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during SHIFT, so keep copies for the flag.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == SHIFT && last_bit)
        ovf <= (a_msb != b_msb) && (bit_d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: WIDTH=8 directed cases plus exhaustive WIDTH=4 sweep.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       s4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input int unsigned a, input int unsigned b, input logic bi);
    exp_t e;
    int   t, sa, sb, st, lim;
    lim    = 1 << (w - 1);
    t      = int'(a) - int'(b) - int'(bi);
    e.diff = 8'(t & ((1 << w) - 1));
    e.bout = (t < 0);
    sa     = (int'(a) >= lim) ? int'(a) - 2 * lim : int'(a);
    sb     = (int'(b) >= lim) ? int'(b) - 2 * lim : int'(b);
    st     = sa - sb - int'(bi);
    e.ovf  = (st >= lim) || (st < -lim);
    return e;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit noise);
    exp_t e;
    int   n, extra;
    q8.push_back(model(8, a, b, bi));
    a8 = a; b8 = b; bin8 = bi; s8 = 1'b1;
    @(posedge clk); #1;
    if (!noise) s8 = 1'b0;
    check("busy_after_start", busy8, 1);
    n = 0;
    while (!done8 && n < 20) begin
      if (noise) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    s8 = 1'b0;
    if (!done8) check("done_timeout", 0, 1);
    else        check("latency", n, 8);
    check("busy_in_done", busy8, 0);
    e = q8.pop_front();
    check("diff8", diff8, e.diff);
    check("bout8", bout8, e.bout);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf8", ovf8, e.ovf);
`endif
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    check("extra_done", extra, 0);
    check("diff8_hold", diff8, e.diff);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    exp_t e;
    int   n;
    q4.push_back(model(4, a, b, bi));
    a4 = a; b4 = b; bin4 = bi; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    n = 0;
    while (!done4 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    e = q4.pop_front();
    if (!done4) check("done4_timeout", 0, 1);
    check("diff4", diff4, 32'(e.diff[3:0]));
    check("bout4", bout4, e.bout);
    @(posedge clk); #1;
  endtask

  initial begin
    int extra;
    s8 = 0; a8 = '0; b8 = '0; bin8 = 0;
    s4 = 0; a4 = '0; b4 = '0; bin4 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bout", bout8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'h05, 8'h03, 1'b0, 0);
    check("k_05_03", diff8, 8'h02);
    run8(8'h03, 8'h05, 1'b0, 0);
    check("k_03_05", diff8, 8'hFE);
    run8(8'h00, 8'h00, 1'b1, 0);
    check("k_00_00_1", diff8, 8'hFF);
    run8(8'h80, 8'h01, 1'b0, 0);
    check("k_80_01", diff8, 8'h7F);
    run8(8'h10, 8'h01, 1'b0, 0);
    run8(8'h7F, 8'hFF, 1'b0, 0);
    run8(8'hFF, 8'hFF, 1'b1, 0);
    run8(8'h80, 8'h00, 1'b1, 0);
    run8(8'h3C, 8'hA5, 1'b1, 1);
    for (int i = 0; i < 6; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // abort in the 4th SHIFT cycle
    run8(8'h5A, 8'h13, 1'b0, 0);
    a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", diff8, 0);
    check("abort_bout", bout8, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", ovf8, 0);
`endif
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    check("abort_no_done", extra, 0);
    run8(8'hFF, 8'h01, 1'b0, 0);
    check("k_ff_01", diff8, 8'hFE);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run4(4'(ia), 4'(ib), 1'(ic));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
